dmem_arbiter: RTL

- Two-master arbiter/sequencer for the shared data memory port.
- Masters: the single-cycle core's load/store path, and a debug/loader master used to preload or inspect data memory.
- Serialises accesses onto a registered-read memory port and stalls the core (PC hold) until its access completes.
- Sits between the core datapath (ALU address, RD2 store data, DMWr/DMCtrl) and the data memory.

---
 rtl/dmem_arbiter_if.sv | 50 +++++
 rtl/dmem_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of the core, debug and memory-side signals around the data memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding core/debug/memory side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              cpu_req;
  logic              cpu_we;
  logic [2:0]        cpu_ctrl;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_done;
  logic              cpu_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ready;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [2:0]        mem_ctrl;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_ctrl, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ready, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_ctrl, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_ctrl, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ready, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_ctrl, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter serialising core and debug accesses onto a registered-read data memory.
// Define DMEM_ARB_PERF_EN to add saturating stall/debug-access counters (stall_cnt_o, dbg_cnt_o).
module dmem_arbiter #(
  parameter int         ADDR_W   = 32,
  parameter int         DATA_W   = 32,
  parameter logic [2:0] DBG_CTRL = 3'b010
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]   stall_cnt_o,
  output logic [31:0]   dbg_cnt_o
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CPU_ISS = 3'd1,
    CPU_RSP = 3'd2,
    DBG_ISS = 3'd3,
    DBG_RSP = 3'd4
  } state_e;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DBG = 1'b1
  } gnt_e;

  state_e            state_q, state_d;
  gnt_e              lastGnt_q, lastGnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] dbgRdata_q, dbgRdata_d;

  logic              memEn;
  logic              memWe;
  logic [2:0]        memCtrl;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic              cpuDone;
  logic              cpuStall;
  logic              dbgReady;
  logic              dbgRvalid;

  // Every access returns through IDLE, so the grant decision only ever happens there.
  always_comb begin
    state_d   = state_q;
    lastGnt_d = lastGnt_q;
    memEn     = 1'b0;
    memWe     = 1'b0;
    memCtrl   = 3'b000;
    memAddr   = '0;
    memWdata  = '0;
    cpuDone   = 1'b0;
    dbgReady  = 1'b0;
    dbgRvalid = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cpu_req && (!bus.dbg_req || lastGnt_q == GNT_DBG)) begin
          state_d   = CPU_ISS;
          lastGnt_d = GNT_CPU;
        end else if (bus.dbg_req) begin
          state_d   = DBG_ISS;
          lastGnt_d = GNT_DBG;
        end
      end
      CPU_ISS: begin
        memEn    = 1'b1;
        memWe    = bus.cpu_we;
        memCtrl  = bus.cpu_ctrl;
        memAddr  = bus.cpu_addr;
        memWdata = bus.cpu_wdata;
        if (bus.cpu_we) begin
          cpuDone = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = CPU_RSP;
        end
      end
      CPU_RSP: begin
        cpuDone = 1'b1;
        state_d = IDLE;
      end
      DBG_ISS: begin
        memEn    = 1'b1;
        memWe    = bus.dbg_we;
        memCtrl  = DBG_CTRL;
        memAddr  = bus.dbg_addr;
        memWdata = bus.dbg_wdata;
        dbgReady = 1'b1;
        state_d  = bus.dbg_we ? IDLE : DBG_RSP;
      end
      DBG_RSP: begin
        dbgRvalid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata_d    = (state_q == CPU_RSP) ? bus.mem_rdata : rdata_q;
    dbgRdata_d = (state_q == DBG_RSP) ? bus.mem_rdata : dbgRdata_q;
  end

  // Reset lands in IDLE with the debug master marked as last served, so the core wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lastGnt_q  <= GNT_DBG;
      rdata_q    <= '0;
      dbgRdata_q <= '0;
    end else begin
      state_q    <= state_d;
      lastGnt_q  <= lastGnt_d;
      rdata_q    <= rdata_d;
      dbgRdata_q <= dbgRdata_d;
    end
  end

  assign cpuStall = bus.cpu_req & ~cpuDone;

  assign bus.mem_en     = memEn;
  assign bus.mem_we     = memWe;
  assign bus.mem_ctrl   = memCtrl;
  assign bus.mem_addr   = memAddr;
  assign bus.mem_wdata  = memWdata;
  assign bus.cpu_done   = cpuDone;
  assign bus.cpu_stall  = cpuStall;
  assign bus.cpu_rdata  = (state_q == CPU_RSP) ? bus.mem_rdata : rdata_q;
  assign bus.dbg_ready  = dbgReady;
  assign bus.dbg_rvalid = dbgRvalid;
  assign bus.dbg_rdata  = (state_q == DBG_RSP) ? bus.mem_rdata : dbgRdata_q;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] stallCnt_q;
  logic [31:0] dbgCnt_q;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt_q <= 32'd0;
      dbgCnt_q   <= 32'd0;
    end else begin
      if (cpuStall && (stallCnt_q != 32'hFFFF_FFFF)) begin
        stallCnt_q <= stallCnt_q + 32'd1;
      end
      if (dbgReady && (dbgCnt_q != 32'hFFFF_FFFF)) begin
        dbgCnt_q <= dbgCnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt_o = stallCnt_q;
  assign dbg_cnt_o   = dbgCnt_q;
`endif

endmodule
